fdiv: RTL and testbench

FDIV -- requirements
Module: fdiv

---
 rtl/fdiv.sv | 184 ++++++++++++++++++
 tb/tb_fdiv.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fdiv.sv
// Single-precision divider: restoring radix-2, fixed 29-cycle start-to-done latency, start ignored while busy.
// Rounding is truncation by default; define FDIV_RNE_EN for round-to-nearest-even at identical latency.
module fdiv (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        busy,
    output logic        done,
    output logic [31:0] out
);

    typedef enum logic [2:0] {IDLE, LOAD, DIV, NORM, DONE} state_t;

    localparam logic [4:0]  ITERS   = 5'd26;
    localparam logic [31:0] QNAN    = 32'h7FC00000;

    state_t             state, state_nxt;
    logic [31:0]        a_q, b_q;
    logic               sign_q;
    logic signed [9:0]  exp_q;
    logic [23:0]        dsr_q;
    logic [24:0]        rem_q;
    logic [25:0]        quo_q;
    logic [4:0]         cnt_q;
    logic               spec_q;
    logic [31:0]        spec_res_q;

    // Operand unpack from the captured inputs
    logic [7:0]         ea, eb;
    logic [22:0]        fa, fb;
    logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [23:0]        ma, mb;
    logic               lt;
    logic [24:0]        dvd;
    logic               sign_ld;
    logic signed [9:0]  exp_ld;
    logic               spec_ld;
    logic [31:0]        spec_val;

    assign ea      = a_q[30:23];
    assign eb      = b_q[30:23];
    assign fa      = a_q[22:0];
    assign fb      = b_q[22:0];
    assign a_zero  = (ea == 8'd0);
    assign b_zero  = (eb == 8'd0);
    assign a_inf   = (ea == 8'hFF) && (fa == 23'd0);
    assign b_inf   = (eb == 8'hFF) && (fb == 23'd0);
    assign a_nan   = (ea == 8'hFF) && (fa != 23'd0);
    assign b_nan   = (eb == 8'hFF) && (fb != 23'd0);
    assign ma      = {1'b1, fa};
    assign mb      = {1'b1, fb};
    assign lt      = (ma < mb);
    // Pre-doubling keeps the quotient in [1,2) so bit 25 of the quotient is always the leading one
    assign dvd     = lt ? {ma, 1'b0} : {1'b0, ma};
    assign sign_ld = a_q[31] ^ b_q[31];
    assign exp_ld  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127 - $signed({9'd0, lt});

    always_comb begin
        spec_ld  = 1'b1;
        spec_val = QNAN;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_val = QNAN;
        end else if (b_zero || a_inf) begin
            spec_val = {sign_ld, 8'hFF, 23'd0};
        end else if (a_zero || b_inf) begin
            spec_val = {sign_ld, 31'd0};
        end else begin
            spec_ld = 1'b0;
        end
    end

    // One restoring step per DIV cycle
    logic [25:0] trial;
    logic        qbit;
    logic [24:0] rem_sel;

    assign trial   = {1'b0, rem_q} - {2'b00, dsr_q};
    assign qbit    = ~trial[25];
    assign rem_sel = qbit ? trial[24:0] : rem_q;

    // Normalisation and rounding
    logic              inc;
    logic [24:0]       mant_sum;
    logic              carry;
    logic [22:0]       frac;
    logic signed [9:0] exp_fin;
    logic [31:0]       result;

`ifdef FDIV_RNE_EN
    logic sticky;
    assign sticky = |rem_q;
    assign inc    = quo_q[1] & (quo_q[0] | sticky | quo_q[2]);
`else
    logic unused_grs;
    assign unused_grs = ^quo_q[1:0];
    assign inc        = 1'b0;
`endif

    assign mant_sum = {1'b0, quo_q[25:2]} + {24'd0, inc};
    assign carry    = mant_sum[24];
    assign frac     = carry ? 23'd0 : mant_sum[22:0];
    assign exp_fin  = exp_q + $signed({9'd0, carry});

    logic unused_lead;
    assign unused_lead = mant_sum[23];

    always_comb begin
        result = {sign_q, exp_fin[7:0], frac};
        if (spec_q) begin
            result = spec_res_q;
        end else if (exp_fin >= 10'sd255) begin
            result = {sign_q, 8'hFF, 23'd0};
        end else if (exp_fin <= 10'sd0) begin
            result = {sign_q, 31'd0};
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = DIV;
            DIV:     if (cnt_q == ITERS) state_nxt = NORM;
            NORM:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            sign_q     <= 1'b0;
            exp_q      <= 10'sd0;
            dsr_q      <= 24'd0;
            rem_q      <= 25'd0;
            quo_q      <= 26'd0;
            cnt_q      <= 5'd0;
            spec_q     <= 1'b0;
            spec_res_q <= 32'd0;
            out        <= 32'd0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q <= rs1;
                        b_q <= rs2;
                    end
                end
                LOAD: begin
                    sign_q     <= sign_ld;
                    exp_q      <= exp_ld;
                    dsr_q      <= mb;
                    rem_q      <= dvd;
                    quo_q      <= 26'd0;
                    cnt_q      <= 5'd0;
                    spec_q     <= spec_ld;
                    spec_res_q <= spec_val;
                end
                DIV: begin
                    // The final DIV cycle only hands over to NORM, fixing total latency at 29
                    if (cnt_q != ITERS) begin
                        rem_q <= {rem_sel[23:0], 1'b0};
                        quo_q <= {quo_q[24:0], qbit};
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                NORM: begin
                    out <= result;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_fdiv.sv
// Directed bench for fdiv: checks result, 29-cycle latency, busy/done behaviour and reset abandonment.
module tb_fdiv;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy;
    logic        done;
    logic [31:0] out;

    int n_vec;
    int n_err;

    fdiv dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .rs1   (rs1),
        .rs2   (rs2),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Issue one divide, wait (bounded) for done, check latency, busy and result
    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_out, input string tag);
        int   lat;
        logic busy_ok;
        @(negedge clk);
        rs1   = a;
        rs2   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        while (!done && lat < 40) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd29);
        check({tag, "_out"}, out, exp_out);
        check({tag, "_busy"}, {31'd0, busy_ok & busy}, 32'd1);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, {30'd0, done, busy}, 32'd0);
    endtask

    initial begin
        int          cyc;
        int          pulses;
        int          first_lat;
        logic [31:0] first_out;
        logic [31:0] third;

        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        start = 1'b0;
        rs1   = 32'd0;
        rs2   = 32'd0;
`ifdef FDIV_RNE_EN
        third = 32'h3EAAAAAB;
`else
        third = 32'h3EAAAAAA;
`endif

        #2 reset = 1'b1;
        #1;
        check("rst_state", {out[31:0]}, 32'd0);
        check("rst_flags", {30'd0, busy, done}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        run_div(32'h40C00000, 32'h40000000, 32'h40400000, "six_div_two");
        run_div(32'h3F800000, 32'h40400000, third,        "one_third");
        run_div(32'hBF800000, 32'h00000000, 32'hFF800000, "neg_div_zero");
        run_div(32'h00000000, 32'h00000000, 32'h7FC00000, "zero_div_zero");
        run_div(32'h7F000000, 32'h3E800000, 32'h7F800000, "overflow");
        run_div(32'h00800000, 32'h40800000, 32'h00000000, "underflow");
        run_div(32'hC0C00000, 32'h40000000, 32'hC0400000, "neg_six");
        run_div(32'h3F800000, 32'h7F800000, 32'h00000000, "fin_div_inf");
        run_div(32'h7F800000, 32'hC0000000, 32'hFF800000, "inf_div_neg");
        run_div(32'h7FC00001, 32'h3F800000, 32'h7FC00000, "nan_in");
        run_div(32'h7F800000, 32'h7F800000, 32'h7FC00000, "inf_div_inf");
        run_div(32'h40800000, 32'h40800000, 32'h3F800000, "four_div_four");
        run_div(32'h00400000, 32'h40000000, 32'h00000000, "denorm_flush");

        // Second start 5 cycles in is dropped; a start during the DONE cycle is dropped too
        @(negedge clk);
        rs1   = 32'h40C00000;
        rs2   = 32'h40000000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        pulses    = 0;
        first_lat = 0;
        first_out = 32'd0;
        for (cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (cyc == 4) begin
                rs1   = 32'h3F800000;
                rs2   = 32'h40400000;
                start = 1'b1;
            end
            if (done) begin
                pulses++;
                if (pulses == 1) begin
                    first_lat = cyc;
                    first_out = out;
                end
                start = 1'b1;
            end
        end
        check("ovl_pulses", 32'(pulses), 32'd1);
        check("ovl_lat", 32'(first_lat), 32'd29);
        check("ovl_out", first_out, 32'h40400000);
        check("done_cycle_start", {31'd0, busy}, 32'd0);

        // Reset in the middle of a divide abandons it
        @(negedge clk);
        rs1   = 32'h3F800000;
        rs2   = 32'h40400000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_flags", {30'd0, busy, done}, 32'd0);
        check("midrst_out", out, 32'd0);
        @(negedge clk);
        reset  = 1'b0;
        pulses = 0;
        for (cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("midrst_no_done", 32'(pulses), 32'd0);

        run_div(32'h40C00000, 32'h40000000, 32'h40400000, "after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
